// File: rtl/regfile_scoreboard_if.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_if
//
// Purpose:
//   Bundles the read, issue, write-back and flush signals that connect the
//   decode/issue stage and the write-back stage to regfile_scoreboard.
//   The clock and the reset are not part of this bundle; they are plain
//   module ports.
//
// Signals (master = pipeline side, slave = register file):
//   rd_en        m->s  capture read results this cycle
//   rd_addr      m->s  NRP*AW flat read addresses, port i at [i*AW +: AW]
//   rd_data      s->m  NRP*XLEN registered read data, port i at [i*XLEN +: XLEN]
//   rd_busy      s->m  NRP registered busy flags, one per read port
//   issue_valid  m->s  an instruction writing issue_rd is issued
//   issue_rd     m->s  destination register of the issued instruction
//   wb_valid     m->s  write-back valid
//   wb_rd        m->s  write-back destination register
//   wb_data      m->s  write-back data
//   flush        m->s  cancel every outstanding busy mark
//   busy_vec     s->m  scoreboard state, bit r set = register r busy
// -----------------------------------------------------------------------------
interface regfile_scoreboard_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
);
    // read side
    logic                 rd_en;
    logic [NRP*AW-1:0]    rd_addr;
    logic [NRP*XLEN-1:0]  rd_data;
    logic [NRP-1:0]       rd_busy;

    // issue side
    logic                 issue_valid;
    logic [AW-1:0]        issue_rd;

    // write-back side
    logic                 wb_valid;
    logic [AW-1:0]        wb_rd;
    logic [XLEN-1:0]      wb_data;

    // control / status
    logic                 flush;
    logic [NREG-1:0]      busy_vec;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        input  rd_busy,
        output issue_valid,
        output issue_rd,
        output wb_valid,
        output wb_rd,
        output wb_data,
        output flush,
        input  busy_vec
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        output rd_busy,
        input  issue_valid,
        input  issue_rd,
        input  wb_valid,
        input  wb_rd,
        input  wb_data,
        input  flush,
        output busy_vec
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Purpose:
//   Integer register file for the decode stage with NRP registered read ports,
//   one write-back port and a per-register busy scoreboard used by the hazard
//   and stall logic to detect read-after-write dependencies.
//
//   Register 0 is hard-wired: it reads as zero, ignores writes and is never
//   marked busy.
//
//   Scoreboard priority for every register r != 0 on each clock edge:
//     flush  >  issue to r (set)  >  write-back to r (clear)  >  hold
//   The read ports sample the post-update busy value, so a read in the same
//   cycle as an issue, write-back or flush already observes its effect.
//
// Configuration:
//   RF_BYPASS_EN  - when defined, a same-cycle write-back to the address being
//                   read is forwarded to rd_data. When undefined, the read
//                   returns the stored value and the new data shows up on the
//                   next read. The scoreboard behaves the same either way.
//
// Ports:
//   clk   in   clock, all state updates on the rising edge
//   rst   in   asynchronous reset, active low (asserted when 0)
//   bus   slave modport of regfile_scoreboard_if (read, issue, write-back,
//              flush and busy_vec signals)
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_scoreboard_if.slave    bus
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // The whole array must clear on reset, so it is built from flops rather
    // than a RAM macro. Entry 0 is never written and therefore stays zero.
    logic [XLEN-1:0]      rf_reg [NREG];

    logic [NREG-1:0]      busy_reg;
    logic [NREG-1:0]      busy_next;

    logic [NRP*XLEN-1:0]  rd_data_reg;
    logic [NRP*XLEN-1:0]  rd_data_next;
    logic [NRP-1:0]       rd_busy_reg;
    logic [NRP-1:0]       rd_busy_next;

    // A write-back to x0 is discarded here, which also keeps x0 out of the
    // bypass path.
    logic                 wr_en;
    assign wr_en = bus.wb_valid && (bus.wb_rd != '0);

    genvar gi;

    // -------------------------------------------------------------------------
    // Scoreboard next state
    // -------------------------------------------------------------------------
    assign busy_next[0] = 1'b0;

    generate
        for (gi = 1; gi < NREG; gi++) begin : g_busy
            localparam logic [AW-1:0] REG_IDX = AW'(gi);

            logic issue_hit;
            logic wb_hit;

            assign issue_hit = bus.issue_valid && (bus.issue_rd == REG_IDX);
            assign wb_hit    = bus.wb_valid    && (bus.wb_rd    == REG_IDX);

            // Issue is tested before write-back so that an instruction issued
            // in the same cycle as an older write-back to the same register
            // keeps the register busy.
            assign busy_next[gi] = bus.flush ? 1'b0 :
                                   issue_hit ? 1'b1 :
                                   wb_hit    ? 1'b0 :
                                               busy_reg[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NRP; gi++) begin : g_port
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] value;

            assign addr = bus.rd_addr[gi*AW +: AW];

`ifdef RF_BYPASS_EN
            // wr_en already excludes x0, so the forward never hits address 0.
            assign value = (addr == '0)                  ? '0          :
                           (wr_en && (bus.wb_rd == addr)) ? bus.wb_data :
                                                           rf_reg[addr];
`else
            assign value = (addr == '0) ? '0 : rf_reg[addr];
`endif

            // Results hold while rd_en is low.
            assign rd_data_next[gi*XLEN +: XLEN] = bus.rd_en ? value
                                                             : rd_data_reg[gi*XLEN +: XLEN];
            assign rd_busy_next[gi]              = bus.rd_en ? busy_next[addr]
                                                             : rd_busy_reg[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Register file array
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (wr_en) begin
            rf_reg[bus.wb_rd] <= bus.wb_data;
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard and read result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg    <= '0;
            rd_data_reg <= '0;
            rd_busy_reg <= '0;
        end else begin
            busy_reg    <= busy_next;
            rd_data_reg <= rd_data_next;
            rd_busy_reg <= rd_busy_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.rd_data  = rd_data_reg;
    assign bus.rd_busy  = rd_busy_reg;
    assign bus.busy_vec = busy_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Directed scenarios followed by randomized traffic, each cycle compared
// against a reference model kept as plain arrays (register values and busy
// bits). Prints one line per transaction and a final summary line.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRP  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP)) bus ();

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] m_rf   [NREG];
    bit              m_busy [NREG];
    logic [XLEN-1:0] e_data [NRP];
    bit              e_busy [NRP];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_rf[r]   = '0;
            m_busy[r] = 1'b0;
        end
        for (int p = 0; p < NRP; p++) begin
            e_data[p] = '0;
            e_busy[p] = 1'b0;
        end
    endtask

    function automatic logic [NREG-1:0] model_busy_vec();
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic check_outputs(input string ctx);
        for (int p = 0; p < NRP; p++) begin
            check_eq($sformatf("%s rd_data[%0d]", ctx, p), bus.rd_data[p*XLEN +: XLEN], e_data[p]);
            check_eq($sformatf("%s rd_busy[%0d]", ctx, p), 64'(bus.rd_busy[p]), 64'(e_busy[p]));
        end
        check_eq($sformatf("%s busy_vec", ctx), 64'(bus.busy_vec), 64'(model_busy_vec()));
    endtask

    task automatic set_idle();
        bus.rd_en       = 1'b0;
        bus.rd_addr     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        bus.flush       = 1'b0;
    endtask

    // One clock of traffic: drive on the falling edge, advance the model,
    // then compare one time unit after the rising edge.
    task automatic drive_cycle(input bit rde, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input bit iv, input logic [AW-1:0] ir,
                               input bit wv, input logic [AW-1:0] wr, input logic [XLEN-1:0] wd,
                               input bit fl, input string ctx);
        bit              nb    [NREG];
        logic [AW-1:0]   addrs [NRP];
        @(negedge clk);
        bus.rd_en       = rde;
        bus.rd_addr     = {a1, a0};
        bus.issue_valid = iv;
        bus.issue_rd    = ir;
        bus.wb_valid    = wv;
        bus.wb_rd       = wr;
        bus.wb_data     = wd;
        bus.flush       = fl;

        // Busy update applied lowest priority first so later steps override.
        nb = m_busy;
        if (wv) nb[wr] = 1'b0;
        if (iv) nb[ir] = 1'b1;
        if (fl) for (int r = 0; r < NREG; r++) nb[r] = 1'b0;
        nb[0] = 1'b0;

        addrs[0] = a0;
        addrs[1] = a1;
        if (rde) begin
            for (int p = 0; p < NRP; p++) begin
                if (addrs[p] == 0)
                    e_data[p] = '0;
`ifdef RF_BYPASS_EN
                else if (wv && wr == addrs[p])
                    e_data[p] = wd;
`endif
                else
                    e_data[p] = m_rf[addrs[p]];
                e_busy[p] = nb[addrs[p]];
            end
        end
        if (wv && wr != 0) m_rf[wr] = wd;
        m_busy = nb;

        @(posedge clk);
        #1;
        $display("[TB] %s rd=%0b(%0d,%0d) iss=%0b(%0d) wb=%0b(%0d,%h) fl=%0b busy=%h",
                 ctx, rde, a0, a1, iv, ir, wv, wr, wd, fl, bus.busy_vec);
        check_outputs(ctx);
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic async_reset(input int hold);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        $display("[TB] async reset asserted");
        check_outputs("async_rst");
        bus.rd_en       = 1'b1;
        bus.rd_addr     = {5'd5, 5'd3};
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = 5'd5;
        bus.wb_data     = 64'hAA;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        check_outputs("rst_hold");
        set_idle();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        bit              rde, iv, wv, fl;
        logic [AW-1:0]   a0, a1, ir, wr;
        logic [XLEN-1:0] wd;

        // Reset held with an active write-back that must be ignored.
        set_idle();
        model_reset();
        rst          = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd5;
        bus.wb_data  = 64'hAA;
        repeat (3) @(negedge clk);
        $display("[TB] reset held");
        check_outputs("reset");
        set_idle();
        rst = 1'b1;

        drive_cycle(1, 5'd5, 5'd0, 0, 0, 0, 0, 0, 0, "rst_read");
        check_eq("rst_read x5", bus.rd_data[0 +: XLEN], 64'h0);

        // Write then read on both ports with the same address.
        drive_cycle(0, 0, 0, 0, 0, 1, 5'd7, 64'h1234_5678_9ABC_DEF0, 0, "wb_x7");
        drive_cycle(1, 5'd7, 5'd7, 0, 0, 0, 0, 0, 0, "rd_x7x7");
        check_eq("x7 port0", bus.rd_data[0 +: XLEN], 64'h1234_5678_9ABC_DEF0);
        check_eq("x7 port1", bus.rd_data[XLEN +: XLEN], 64'h1234_5678_9ABC_DEF0);

        // x0 ignores writes.
        drive_cycle(0, 0, 0, 0, 0, 1, 5'd0, 64'hDEAD_BEEF, 0, "wb_x0");
        drive_cycle(1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, "rd_x0");
        check_eq("x0 read", bus.rd_data[0 +: XLEN], 64'h0);

        // Same-cycle write and read.
        drive_cycle(1, 5'd3, 5'd0, 0, 0, 1, 5'd3, 64'h55, 0, "bypass_x3");
`ifdef RF_BYPASS_EN
        check_eq("bypass x3", bus.rd_data[0 +: XLEN], 64'h55);
`else
        check_eq("nobypass x3", bus.rd_data[0 +: XLEN], 64'h0);
`endif
        drive_cycle(1, 5'd3, 5'd0, 0, 0, 0, 0, 0, 0, "rd_x3");
        check_eq("x3 after write", bus.rd_data[0 +: XLEN], 64'h55);

        // Scoreboard set and clear.
        drive_cycle(0, 0, 0, 1, 5'd9, 0, 0, 0, 0, "issue_x9");
        drive_cycle(1, 5'd9, 5'd0, 0, 0, 0, 0, 0, 0, "rd_x9_busy");
        check_eq("x9 busy", 64'(bus.rd_busy[0]), 64'h1);
        drive_cycle(1, 5'd9, 5'd0, 0, 0, 1, 5'd9, 64'h77, 0, "wb_rd_x9");
        check_eq("x9 cleared", 64'(bus.rd_busy[0]), 64'h0);

        // Simultaneous issue and write-back: set wins, data still written.
        drive_cycle(0, 0, 0, 1, 5'd4, 1, 5'd4, 64'h44, 0, "iss_wb_x4");
        check_eq("x4 busy", 64'(bus.busy_vec[4]), 64'h1);
        drive_cycle(1, 5'd4, 5'd0, 1, 5'd0, 0, 0, 0, 0, "rd_x4_iss_x0");
        check_eq("x4 data", bus.rd_data[0 +: XLEN], 64'h44);
        check_eq("x0 never busy", 64'(bus.busy_vec[0]), 64'h0);

        // Flush cancels all marks, discards same-cycle issue, keeps write.
        drive_cycle(0, 0, 0, 1, 5'd2, 0, 0, 0, 0, "issue_x2");
        drive_cycle(0, 0, 0, 1, 5'd6, 0, 0, 0, 0, "issue_x6");
        drive_cycle(0, 0, 0, 1, 5'd8, 1, 5'd6, 64'h9, 1, "flush");
        check_eq("flush busy_vec", 64'(bus.busy_vec), 64'h0);
        drive_cycle(1, 5'd6, 5'd2, 0, 0, 0, 0, 0, 0, "rd_x6");
        check_eq("x6 after flush", bus.rd_data[0 +: XLEN], 64'h9);

        // Randomized traffic, biased to a few registers to create hazards.
        for (int i = 0; i < 1200; i++) begin
            if (i == 600) async_reset(2);
            rde = ($urandom_range(0, 3) != 0);
            iv  = ($urandom_range(0, 9) < 4);
            wv  = ($urandom_range(0, 1) == 1);
            fl  = ($urandom_range(0, 19) == 0);
            a0  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            a1  = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, 7));
            ir  = AW'($urandom_range(0, 7));
            wr  = ($urandom_range(0, 1) == 1) ? a0 : AW'($urandom_range(0, 7));
            wd  = {$urandom, $urandom};
            drive_cycle(rde, a0, a1, iv, ir, wv, wr, wd, fl, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
